mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WID, default 32, meaning byte-address width.
REQ-002 SHALL have parameter IF_BLK_BYTES, default 64, meaning bytes per instruction-cache block fill.
REQ-003 SHALL have one clock and a synchronous, active-high reset: port clk, input, 1 bit, the clock; port rst, input, 1 bit, the reset.
REQ-004 SHALL have port rdy, input, 1 bit: global enable; when low, all state is frozen.
REQ-005 SHALL have port mem_din, input, 8 bit: RAM read byte.
REQ-006 SHALL have port mem_dout, output, 8 bit: RAM write byte.
REQ-007 SHALL have port mem_a, output, ADDR_WID bit: RAM byte address.
REQ-008 SHALL have port mem_wr, output, 1 bit: RAM write strobe (1 = write).
REQ-009 SHALL have ports if_en (input, 1), if_pc (input, ADDR_WID), if_done (output, 1) and if_data (output, IF_BLK_BYTES*8): the instruction-block fill channel.
REQ-010 SHALL have ports lsb_en (input, 1), lsb_wr (input, 1), lsb_len (input, 2; 0/1/3 = 1/2/4 bytes), lsb_addr (input, ADDR_WID), lsb_wdata (input, 32), lsb_done (output, 1) and lsb_rdata (output, 32): the load/store channel.
REQ-011 SHALL have port rob_clear, input, 1 bit: misprediction flush.
REQ-012 SHALL have port io_buffer_full, input, 1 bit, only when MEMC_IO_STALL_EN is defined.

Function
REQ-013 SHALL implement the states IDLE, IFETCH, LOAD and STORE.
REQ-014 SHALL, in IDLE, sample requests at each enabled edge; lsb_en wins over if_en; the losing request stays pending while its en is held.
REQ-015 SHALL latch base address, length N (IF_BLK_BYTES, or lsb_len+1), direction and write data at the accepting edge E0, and enter IFETCH, LOAD (lsb_wr=0) or STORE (lsb_wr=1).
REQ-016 SHALL register mem_a, mem_dout and mem_wr; byte k is presented in the cycle after edge E0+k, for k = 0..N-1, at address base+k (ADDR_WID wrap-around, no alignment check).
REQ-017 SHALL treat reads as having 1-cycle RAM latency: byte k appears on mem_din after edge E0+k+1, is captured at edge E0+k+2, and is placed at bits [8k+7:8k], little-endian.
REQ-018 SHALL, for reads, pulse done high for exactly one cycle at edge E0+N+1 with the data valid in that cycle, and return to IDLE at that edge; the next request is accepted no earlier than E0+N+2.
REQ-019 SHALL, for stores, drive mem_dout = lsb_wdata byte k with mem_wr=1, pulse lsb_done at edge E0+N, and return to IDLE.
REQ-020 SHALL zero-fill lsb_rdata above byte N-1; sign extension is the requester's job.
REQ-021 SHALL hold if_data and lsb_rdata stable until the next done of the same channel.
REQ-022 SHALL drive mem_wr=0 in every cycle not in STORE byte issue, including when idle.
REQ-023 SHALL, on rob_clear, abort a LOAD, assert no lsb_done for it and go to IDLE at the next edge; IFETCH and STORE always complete.
REQ-024 SHALL drop a new lsb load request presented together with rob_clear; a simultaneous store request is accepted.
REQ-025 SHALL, while rdy=0, hold the state, counters and registered outputs, force mem_wr to 0 combinationally and capture no mem_din.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, go to IDLE, clear the byte counter, set mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0 and lsb_rdata=0, and drop any in-flight operation without a done, regardless of rdy.
REQ-027 SHALL accept a request at the first enabled edge after rst deasserts.

Configuration
REQ-028 SHALL, with MEMC_IO_STALL_EN defined, not issue a STORE byte whose address[17:16]==2'b11 while io_buffer_full=1: the counter and outputs hold with mem_wr=0 until io_buffer_full=0.
REQ-029 SHALL, without MEMC_IO_STALL_EN, omit the io_buffer_full port and never stall.

Verification
REQ-030 SHALL verify an IFETCH fill: if_en=1 with if_pc=0x40, RAM[0x40+k]=k -> 64 reads at 0x40..0x7F, if_done pulse at E0+65, if_data byte k = k.
REQ-031 SHALL verify a simultaneous request: if_en and lsb_en (load, len=3, addr 0x100) on the same edge -> the LOAD is served first, lsb_done at E0+5, then the IFETCH starts.
REQ-032 SHALL verify a halfword store: lsb_addr 0x200, wdata 0xAABBCCDD, len=1 -> writes 0xDD at 0x200 and 0xCC at 0x201, lsb_done at E0+2, RAM[0x202] unchanged.
REQ-033 SHALL verify flush mid-load: rob_clear during byte 1 of a 4-byte LOAD -> no lsb_done, back to IDLE next edge, a queued if_en is accepted after that.
REQ-034 SHALL verify a rdy stall: rdy=0 for 5 cycles mid-IFETCH -> mem_wr=0, if_done delayed by exactly 5 cycles, data correct.
REQ-035 SHALL verify the I/O stall (MEMC_IO_STALL_EN defined): a store to 0x30000 with io_buffer_full=1 for 3 cycles -> no write until release, lsb_done 3 cycles late.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating an instruction-block fill channel and a load/store channel; MEMC_IO_STALL_EN adds an io_buffer_full stall for stores into the I/O window (addr[17:16]==2'b11)
module mem_ctrl #(
  parameter int ADDR_WID     = 32,
  parameter int IF_BLK_BYTES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [ADDR_WID-1:0]       mem_a,
  output logic                      mem_wr,
  input  logic                      if_en,
  input  logic [ADDR_WID-1:0]       if_pc,
  output logic                      if_done,
  output logic [IF_BLK_BYTES*8-1:0] if_data,
  input  logic                      lsb_en,
  input  logic                      lsb_wr,
  input  logic [1:0]                lsb_len,
  input  logic [ADDR_WID-1:0]       lsb_addr,
  input  logic [31:0]               lsb_wdata,
  output logic                      lsb_done,
  output logic [31:0]               lsb_rdata,
  input  logic                      rob_clear
`ifdef MEMC_IO_STALL_EN
  ,
  input  logic                      io_buffer_full
`endif
);
  localparam int BW = IF_BLK_BYTES * 8;
  localparam int IW = $clog2(IF_BLK_BYTES);
  localparam int CW = IW + 1;
  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, len;
  logic [IW-1:0] idx;
  logic [ADDR_WID-1:0] base, nxt_a;
  logic [31:0] wdata;
  logic [BW-1:0] fill, fill_n;
  logic wr_q, stall, take_lsb, take_if, fin_rd, last_issue, more;
  // cnt counts enabled edges since acceptance; byte cnt+1 is issued next, byte cnt-1 arrives now
  assign nxt_a = base + ADDR_WID'(cnt) + 1'b1;
  assign more = cnt + 1'b1 < len;
  assign fin_rd = cnt == len;
  assign last_issue = cnt + 1'b1 == len;
  assign idx = IW'(cnt - 1'b1);
`ifdef MEMC_IO_STALL_EN
  assign stall = io_buffer_full && (state == IDLE ? lsb_en && lsb_wr && lsb_addr[17:16] == 2'b11
                                                  : state == STORE && more && nxt_a[17:16] == 2'b11);
`else
  assign stall = 1'b0;
`endif
  // a load presented with a flush is dropped; a blocked I/O store holds off the fill channel too
  assign take_lsb = state == IDLE && lsb_en && (lsb_wr || !rob_clear) && !stall;
  assign take_if = state == IDLE && if_en && !take_lsb && !stall;
  // merge the byte returned by RAM into the fill buffer at its little-endian slot
  always_comb begin
    fill_n = fill;
    if (cnt != '0) fill_n[{idx, 3'b000} +: 8] = mem_din;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (rdy) state <= state_n;
  end
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = take_lsb ? (lsb_wr ? STORE : LOAD) : take_if ? IFETCH : IDLE;
      IFETCH:  state_n = fin_rd ? IDLE : IFETCH;
      LOAD:    state_n = fin_rd || rob_clear ? IDLE : LOAD;
      STORE:   state_n = last_issue ? IDLE : STORE;
      default: state_n = IDLE;
    endcase
  end
  // write strobe is gated by rdy so a frozen store never repeats a write
  always_comb mem_wr = wr_q && rdy;
  // datapath: request latch, byte issue, read capture and done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      len <= '0;
      base <= '0;
      wdata <= '0;
      fill <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      wr_q <= 1'b0;
      if_done <= 1'b0;
      lsb_done <= 1'b0;
      if_data <= '0;
      lsb_rdata <= '0;
    end else if (rdy) begin
      if_done <= 1'b0;
      lsb_done <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        fill <= '0;
        wr_q <= take_lsb && lsb_wr;
        if (take_lsb || take_if) begin
          base <= take_lsb ? lsb_addr : if_pc;
          mem_a <= take_lsb ? lsb_addr : if_pc;
          len <= take_lsb ? CW'(lsb_len) + 1'b1 : CW'(IF_BLK_BYTES);
          mem_dout <= lsb_wdata[7:0];
          wdata <= {8'h00, lsb_wdata[31:8]};
        end
      end else begin
        if (!stall) cnt <= cnt + 1'b1;
        wr_q <= state == STORE && more && !stall;
        if (more && !stall) begin
          mem_a <= nxt_a;
          mem_dout <= wdata[7:0];
          wdata <= {8'h00, wdata[31:8]};
        end
        if (state != STORE) fill <= fill_n;
        if (state == IFETCH && fin_rd) begin
          if_data <= fill_n;
          if_done <= 1'b1;
        end
        if (state == LOAD && fin_rd && !rob_clear) begin
          lsb_rdata <= fill_n[31:0];
          lsb_done <= 1'b1;
        end
        if (state == STORE && last_issue) lsb_done <= 1'b1;
      end
    end
  end
endmodule
